// File: rtl/ntt_pkg.sv
// Shared NTT constants and types.
//   NTT_WIDTH / NTT_Q : default coefficient width and modulus (Kyber q)
//   state_t           : serial modular adder controller states
//   cnt_width()       : bit-counter width able to hold 0..w
package ntt_pkg;
  localparam int NTT_WIDTH = 12;
  localparam int NTT_Q     = 3329;

  typedef enum logic [1:0] {IDLE, ADD, SUB, DONE} state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int NTT_CNT_W = $clog2(NTT_WIDTH + 1);
endpackage

// File: rtl/serial_shift_reg.sv
// W-bit right-shifting register, LSB out first.
//   clk, rst  : clock, async active-high reset (clears contents)
//   load      : parallel load of load_val (wins over shift)
//   shift     : shift right one position
//   sin       : serial input entering at the MSB
//   rotate    : when set, the LSB re-enters at the MSB instead of sin
//   q         : register contents
module serial_shift_reg #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         sin,
  input  logic         rotate,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (load)  q <= load_val;
    else if (shift) q <= {(rotate ? q[0] : sin), q[W-1:1]};
  end
endmodule

// File: rtl/serial_mod_add_ctrl.sv
// Bit-serial modular adder controller: (a + b) mod MODULUS using one
// external 1-bit full-adder slice. An ADD pass forms a+b, a SUB pass forms
// (a+b)-MODULUS by adding ~MODULUS with carry-in 1, then the reduced value
// is selected.
//   clk, rst            : clock, async active-high reset
//   start, ready        : request accepted when ready (IDLE only)
//   a, b                : operands, sampled on accept, expected < MODULUS
//   done, s             : one-cycle done pulse; s held until next accept
//   fa_x, fa_y, fa_cin  : drive to the full-adder slice
//   fa_sum, fa_cout     : results from the full-adder slice
module serial_mod_add_ctrl
  import ntt_pkg::*;
#(
  parameter int WIDTH   = NTT_WIDTH,
  parameter int MODULUS = NTT_Q
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);
  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] Q_V   = WIDTH'(MODULUS);
  localparam logic [WIDTH-1:0] Q_INV = ~Q_V;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic             carry, add_c;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] ra, rb, rq, rs, rd;

  logic accept, in_add, in_sub, last;
  assign accept = (state == IDLE) && start;
  assign in_add = (state == ADD);
  assign in_sub = (state == SUB);
  assign last   = (cnt == LAST);

  // Only the LSBs of the operand registers are observed here; the rest is
  // consumed inside the shift registers.
  logic unused_hi;
  assign unused_hi = ^{ra[WIDTH-1:1], rb[WIDTH-1:1], rq[WIDTH-1:1]};

  serial_shift_reg #(.W(WIDTH)) u_ra (
    .clk(clk), .rst(rst), .load(accept), .load_val(a), .shift(in_add),
    .sin(1'b0), .rotate(1'b0), .q(ra));
  serial_shift_reg #(.W(WIDTH)) u_rb (
    .clk(clk), .rst(rst), .load(accept), .load_val(b), .shift(in_add),
    .sin(1'b0), .rotate(1'b0), .q(rb));
  serial_shift_reg #(.W(WIDTH)) u_rq (
    .clk(clk), .rst(rst), .load(accept), .load_val(Q_INV), .shift(in_sub),
    .sin(1'b0), .rotate(1'b0), .q(rq));
  // rs fills during ADD, then rotates during SUB so it is intact afterwards.
  serial_shift_reg #(.W(WIDTH)) u_rs (
    .clk(clk), .rst(rst), .load(1'b0), .load_val('0),
    .shift(in_add | in_sub), .sin(fa_sum), .rotate(in_sub), .q(rs));
  serial_shift_reg #(.W(WIDTH)) u_rd (
    .clk(clk), .rst(rst), .load(1'b0), .load_val('0), .shift(in_sub),
    .sin(fa_sum), .rotate(1'b0), .q(rd));

  // Register contents as they will be after the final SUB edge, so the
  // selection can happen on that same edge.
  logic [WIDTH-1:0] rs_fin, rd_fin;
  assign rs_fin = {rs[0], rs[WIDTH-1:1]};
  assign rd_fin = {fa_sum, rd[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    done    = 1'b0;
    fa_x    = 1'b0;
    fa_y    = 1'b0;
    fa_cin  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_n = ADD;
      end
      ADD: begin
        fa_x   = ra[0];
        fa_y   = rb[0];
        fa_cin = carry;
        if (last) state_n = SUB;
      end
      SUB: begin
        fa_x   = rs[0];
        fa_y   = rq[0];
        fa_cin = carry;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry <= 1'b0;
      add_c <= 1'b0;
      cnt   <= '0;
      s     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          carry <= 1'b0;
          add_c <= 1'b0;
          cnt   <= '0;
        end
        ADD: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            add_c <= fa_cout;
            carry <= 1'b1;  // +1 of the two's-complement subtraction
          end else begin
            carry <= fa_cout;
          end
        end
        SUB: begin
          carry <= fa_cout;
          cnt   <= last ? '0 : cnt + 1'b1;
          // Final fa_cout is the SUB borrow-free flag: set iff sum >= q.
          if (last) s <= (add_c | fa_cout) ? rd_fin : rs_fin;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_mod_add_ctrl.sv
module tb_serial_mod_add_ctrl;
  localparam int W = 12;
  localparam int LAT = 2 * W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         ready, done;
  logic [W-1:0] s;
  logic         fa_x, fa_y, fa_cin, fa_sum, fa_cout;

  always #5 clk = ~clk;

  // Behavioural full-adder slice.
  assign fa_sum  = fa_x ^ fa_y ^ fa_cin;
  assign fa_cout = (fa_x & fa_y) | (fa_x & fa_cin) | (fa_y & fa_cin);

  serial_mod_add_ctrl #(.WIDTH(W), .MODULUS(3329)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .s(s),
    .fa_x(fa_x), .fa_y(fa_y), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout));

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [W-1:0] sb[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else check("result", int'(s), int'(sb.pop_front()));
    end
  end

  task automatic wait_ready();
    int n;
    for (n = 0; n < 60 && !ready; n++) @(negedge clk);
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  // Launch one op at a negedge; returns cycles until done and fa_cin
  // sampled in cycles 1 (first ADD) and W+1 (first SUB).
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [W-1:0] exp, output int lat,
                        output logic cin_add0, output logic cin_sub0);
    wait_ready();
    a = ta; b = tb_; start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; cin_add0 = 1'bx; cin_sub0 = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) cin_add0 = fa_cin;
      if (n == W + 1) cin_sub0 = fa_cin;
      if (done) begin lat = n; break; end
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int lat, d0;
    logic c0, c1;

    vecs[0] = '{12'd1000, 12'd2000, 12'd3000};
    vecs[1] = '{12'd3000, 12'd1000, 12'd671};
    vecs[2] = '{12'd3328, 12'd3328, 12'd3327};
    vecs[3] = '{12'd0,    12'd0,    12'd0};
    vecs[4] = '{12'd3328, 12'd1,    12'd0};
    vecs[5] = '{12'd2500, 12'd829,  12'd0};
    vecs[6] = '{12'd3328, 12'd0,    12'd3328};
    vecs[7] = '{12'd1,    12'd1,    12'd2};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_s", int'(s), 0);
    check("rst_fa", int'({fa_x, fa_y, fa_cin}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", int'(ready), 1);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, lat, c0, c1);
      check($sformatf("latency_%0d", i), lat, LAT);
      check($sformatf("cin_add0_%0d", i), int'(c0), 0);
      check($sformatf("cin_sub0_%0d", i), int'(c1), 1);
      check($sformatf("s_%0d", i), int'(s), int'(vecs[i].exp));
    end

    // Back-to-back: one op per 2W+2 cycles, s held between ops
    @(negedge clk);
    check("post_done_ready", int'(ready), 1);
    check("s_held", int'(s), 2);

    // start pulses mid-operation are ignored
    wait_ready();
    d0 = done_cnt;
    a = 12'd1500; b = 12'd2000; start = 1'b1;
    sb.push_back(12'd171);
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 3 || n == 20) begin a = 12'd5; b = 12'd6; start = 1'b1; end
      else start = 1'b0;
      if (done) begin lat = n; break; end
      if (ready) check($sformatf("busy_ready_c%0d", n), int'(ready), 0);
    end
    start = 1'b0;
    check("ignore_latency", lat, LAT);
    repeat (4) @(negedge clk);
    check("ignore_one_done", done_cnt - d0, 1);
    check("ignore_s", int'(s), 171);

    // Reset mid-operation aborts without a done pulse
    wait_ready();
    d0 = done_cnt;
    a = 12'd3000; b = 12'd3000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", int'(ready), 1);
    check("abort_s", int'(s), 0);
    check("abort_fa", int'({fa_x, fa_y, fa_cin}), 0);
    check("abort_done", int'(done), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_op(12'd3000, 12'd3000, 12'd2671, lat, c0, c1);
    check("after_abort_latency", lat, LAT);
    check("after_abort_s", int'(s), 2671);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
